imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
- Registered, handshaked immediate generator for the decode stage.
- Generalises the combinational RV32I extender to XLEN 32/64, adds the CSR-zimm format and an explicit illegal-format code, and carries a sideband tag.
- Sits between instruction fetch/decode and the ID/EX register.
- Has a valid/ready input, a 2-entry skid buffer for full-throughput backpressure, and a saturating illegal-format counter.

Parameters:
- XLEN, 32: datapath width; legal values 32 and 64; any other value is a fatal elaboration error.
- TAG_W, 5: sideband tag width (e.g. rd index); passed through unchanged.
- ERRCNT_W, 8: width of the saturating illegal-format counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat this cycle
- instr  in  25  instruction bits [31:7]; port index range 31:7
- immsrc  in  3  format select; encodings listed under Behaviour
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts the beat
- immext  out  XLEN  extended immediate
- out_tag  out  TAG_W  tag belonging to immext
- out_illegal  out  1  beat had immsrc=111
- err_count  out  ERRCNT_W  number of accepted illegal beats, saturating

Behaviour:
- Reset: asynchronous on rst_n low. During and after reset:
  - out_valid=0, in_ready=1, immext=0, out_tag=0, out_illegal=0, err_count=0, skid buffer empty.
  - Beats in flight are discarded.
  - Reset deassertion takes effect at the next clk edge.
- Input handshake: a beat transfers when in_valid&&in_ready at a rising edge. Output handshake: a beat transfers when out_valid&&out_ready.
- immsrc encodings. S denotes instr[31] replicated up to XLEN.
  - 000 I: {S, instr[31:20]}
  - 001 S: {S, instr[31:25], instr[11:7]}
  - 010 B: {S, instr[7], instr[30:25], instr[11:8], 0}
  - 011 J: {S, instr[19:12], instr[20], instr[30:21], 0}
  - 100 U: {S, instr[31:12], 12'b0}. The sign bits only exist when XLEN=64; for XLEN=32 the result is exactly 32 bits.
  - 101 shamt: zero-extended. XLEN=32 uses instr[24:20]; XLEN=64 uses instr[25:20].
  - 110 CSR zimm: zero-extended instr[19:15].
  - 111 illegal: immext=0 and out_illegal=1.
- Latency: exactly 1 cycle from input acceptance to out_valid, provided the output stage is empty or draining.
- Storage: output register plus one skid entry. Order is strictly FIFO.
- Flow control:
  - in_ready is registered and equals !skid_valid.
  - Accept while the output register is empty, or is full and out_ready=1 → beat goes to the output register.
  - Accept while the output register is full and out_ready=0 → beat goes to the skid entry.
  - When the output drains and the skid entry is full → the skid entry moves to the output register, in_ready rises next cycle, and no bubble is inserted.
- Throughput: one beat per cycle while out_ready=1.
- Stall rule: with out_valid=1 and out_ready=0, immext, out_tag and out_illegal stay stable.
- Error counter:
  - Increments on input acceptance of an immsrc=111 beat, not on output.
  - Saturates at all-ones and never wraps.
- Combined error-counter and output-illegal timing: out_illegal reaches the output aligned with its own beat.
- No X on outputs in any state.

Decomposition:
- Package imm_pkg holds:
  - the immsrc localparams IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_SHAMT, IMM_ZIMM, IMM_ILL;
  - a packed struct {immext, tag, illegal} used for both the output register and the skid entry.
- Sub-module imm_decode (combinational, parameter XLEN): maps instr and immsrc to immext and illegal. The pipe module instantiates it once on the input side, and it is reused by the later single-cycle core.

Test Plan:
- XLEN=32, immsrc=000, instr=0xFFF00093 (bits 31:7), out_ready=1 → one cycle later out_valid=1, immext=0xFFFFFFFF, out_illegal=0.
- immsrc=010, instr=0xFE000EE3 → immext=0xFFFFFFFC. immsrc=100, instr=0x12345037 → immext=0x12345000.
- XLEN=64:
  - immsrc=100, instr=0x800000B7 → immext=0xFFFFFFFF80000000.
  - immsrc=101, instr=0x03F09093 → immext=0x3F. The same beat at XLEN=32 → 0x1F.
- Backpressure: out_ready=0, drive beats tags 1,2,3 back-to-back.
  - Tags 1 and 2 are accepted; in_ready=0 from the cycle after tag 2 is accepted.
  - Raise out_ready → outputs 1,2,3 on consecutive cycles with no bubble; in_ready returns to 1.
- Illegal: 300 consecutive immsrc=111 beats with ERRCNT_W=8 → each beat has out_illegal=1 and immext=0; err_count ends at 255.
- Reset mid-operation: pull rst_n low asynchronously while the skid entry is full → out_valid=0 and in_ready=1 immediately, err_count=0; the first post-reset beat emerges with correct data.

Source files
------------

// File: rtl/imm_extend_pipe_pkg.sv
// imm_pkg: shared definitions for the immediate generator.
//   - immsrc format codes (IMM_*)
//   - imm_beat_t: one pipeline beat {immext, tag, illegal}, sized for the
//     widest supported datapath/tag so the same type serves every
//     parameterisation. Narrower users zero-pad on write and slice on read.
package imm_pkg;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_S     = 3'b001;
  localparam logic [2:0] IMM_B     = 3'b010;
  localparam logic [2:0] IMM_J     = 3'b011;
  localparam logic [2:0] IMM_U     = 3'b100;
  localparam logic [2:0] IMM_SHAMT = 3'b101;
  localparam logic [2:0] IMM_ZIMM  = 3'b110;
  localparam logic [2:0] IMM_ILL   = 3'b111;

  localparam int IMM_MAX_W = 64;
  localparam int TAG_MAX_W = 16;

  typedef struct packed {
    logic [IMM_MAX_W-1:0] immext;
    logic [TAG_MAX_W-1:0] tag;
    logic                 illegal;
  } imm_beat_t;

endpackage

// File: rtl/imm_extend_pipe_decode.sv
// imm_decode: combinational immediate extender.
// Ports:
//   instr_i   [31:7]     instruction bits above the opcode
//   immsrc_i  [2:0]      format select (imm_pkg::IMM_*)
//   immext_o  [XLEN-1:0] extended immediate (0 for the illegal code)
//   illegal_o            immsrc_i selected the illegal code
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr_i,
  input  logic [2:0]      immsrc_i,
  output logic [XLEN-1:0] immext_o,
  output logic            illegal_o
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $fatal(1, "imm_decode: XLEN must be 32 or 64");
  end

  // Signed size casts sign-extend from the top bit of each assembled field,
  // which is always instr[31]; unsigned casts zero-extend.
  always_comb begin
    immext_o  = '0;
    illegal_o = 1'b0;
    case (immsrc_i)
      IMM_I:     immext_o = XLEN'($signed(instr_i[31:20]));
      IMM_S:     immext_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      IMM_B:     immext_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                           instr_i[11:8], 1'b0}));
      IMM_J:     immext_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                           instr_i[30:21], 1'b0}));
      IMM_U:     immext_o = XLEN'($signed({instr_i[31:12], 12'b0}));
      IMM_SHAMT: immext_o = (XLEN == 64) ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
      IMM_ZIMM:  immext_o = XLEN'(instr_i[19:15]);
      default:   illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered, valid/ready immediate generator for decode.
// One output register plus one skid entry give full throughput under
// backpressure with a registered in_ready.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          input handshake
//   instr[31:7], immsrc, in_tag input beat
//   out_valid/out_ready        output handshake
//   immext, out_tag, out_illegal output beat
//   err_count                  saturating count of accepted illegal beats
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 5,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:7]         instr,
  input  logic [2:0]          immsrc,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     immext,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_illegal,
  output logic [ERRCNT_W-1:0] err_count
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $fatal(1, "imm_extend_pipe: XLEN must be 32 or 64");
  end
  if (TAG_W < 1 || TAG_W > TAG_MAX_W) begin : g_bad_tag
    $fatal(1, "imm_extend_pipe: TAG_W out of range");
  end

  logic [XLEN-1:0] dec_imm;
  logic            dec_ill;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr_i   (instr),
    .immsrc_i  (immsrc),
    .immext_o  (dec_imm),
    .illegal_o (dec_ill)
  );

  imm_beat_t             in_beat;
  imm_beat_t             out_q, out_d;
  imm_beat_t             skid_q, skid_d;
  logic                  out_valid_q, out_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [ERRCNT_W-1:0]   err_q, err_d;
  logic                  accept;

  always_comb begin
    in_beat.immext  = IMM_MAX_W'(dec_imm);
    in_beat.tag     = TAG_MAX_W'(in_tag);
    in_beat.illegal = dec_ill;
  end

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    err_d        = err_q;

    if (!out_valid_q || out_ready) begin
      // Output slot frees up this cycle. A full skid entry always has
      // priority; in_ready is already low in that case so nothing new
      // can be accepted at the same time.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end

    if (accept && dec_ill && (err_q != '1)) begin
      err_d = err_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      err_q        <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      err_q        <= err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign immext      = out_q.immext[XLEN-1:0];
  assign out_tag     = out_q.tag[TAG_W-1:0];
  assign out_illegal = out_q.illegal;
  assign err_count   = err_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:7] instr;
  logic [2:0]  immsrc;
  logic [4:0]  in_tag;
  logic [31:0] cur_ins;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic [7:0]  err32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  logic [4:0]  tag64;
  logic [7:0]  err64;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(32), .TAG_W(5), .ERRCNT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .immext(imm32),
    .out_tag(tag32), .out_illegal(ill32), .err_count(err32)
  );

  imm_extend_pipe #(.XLEN(64), .TAG_W(5), .ERRCNT_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .instr(instr), .immsrc(immsrc), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .immext(imm64),
    .out_tag(tag64), .out_illegal(ill64), .err_count(err64)
  );

  // Reference: the pipe is a 2-deep FIFO of decoded beats.
  typedef struct {
    logic [31:0] e32;
    logic [63:0] e64;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   err_model = 0;

  // Immediate value computed as a signed integer from the instruction's
  // field weights, then truncated to the datapath width.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                          input int xl);
    longint x, v;
    longint neg;
    x   = longint'(ins);
    neg = ins[31] ? 1 : 0;
    case (src)
      3'd0: v = ((x >> 20) & 4095) - neg * 4096;
      3'd1: v = ((x >> 25) & 127) * 32 + ((x >> 7) & 31) - neg * 4096;
      3'd2: v = ((x >> 8) & 15) * 2 + ((x >> 25) & 63) * 32 + ((x >> 7) & 1) * 2048
                - neg * 4096;
      3'd3: v = ((x >> 21) & 1023) * 2 + ((x >> 20) & 1) * 2048 + ((x >> 12) & 255) * 4096
                - neg * 1048576;
      3'd4: v = (x & 64'hFFFF_F000) - neg * 64'h1_0000_0000;
      3'd5: v = (x >> 20) % ((xl == 64) ? 64 : 32);
      3'd6: v = (x >> 15) % 32;
      default: v = 0;
    endcase
    if (xl == 32) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] src,
                       input logic [4:0] tag);
    in_valid = v;
    cur_ins  = ins;
    instr    = ins[31:7];
    immsrc   = src;
    in_tag   = tag;
  endtask

  task automatic check_state();
    chk("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
    chk("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
    chk("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
    chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
    chk("err32", 64'(err32), 64'(err_model));
    chk("err64", 64'(err64), 64'(err_model));
    if (q.size() > 0) begin
      chk("imm32", 64'(imm32), 64'(q[0].e32));
      chk("imm64", imm64, q[0].e64);
      chk("tag32", 64'(tag32), 64'(q[0].tag));
      chk("tag64", 64'(tag64), 64'(q[0].tag));
      chk("ill32", 64'(ill32), 64'(q[0].ill));
      chk("ill64", 64'(ill64), 64'(q[0].ill));
    end
  endtask

  // Advance one clock: update the model with this cycle's handshakes, then
  // compare at the following falling edge.
  task automatic cycle();
    bit   acc, fire;
    exp_t e;
    acc  = in_valid && (q.size() < 2);
    fire = out_ready && (q.size() > 0);
    if (fire) void'(q.pop_front());
    if (acc) begin
      e.e32 = ref_imm(cur_ins, immsrc, 32)[31:0];
      e.e64 = ref_imm(cur_ins, immsrc, 64);
      e.tag = in_tag;
      e.ill = (immsrc == 3'd7);
      q.push_back(e);
      if (immsrc == 3'd7 && err_model < 255) err_model++;
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  logic [31:0] d_ins[8];
  logic [2:0]  d_src[8];
  logic [31:0] d_e32[8];
  logic [63:0] d_e64[8];

  initial begin
    d_ins = '{32'hFFF00093, 32'hFE000EE3, 32'h12345037, 32'h800000B7,
              32'h03F09093, 32'hFFFFF073, 32'hFE112E23, 32'hFF9FF0EF};
    d_src = '{3'd0, 3'd2, 3'd4, 3'd4, 3'd5, 3'd6, 3'd1, 3'd3};
    d_e32 = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h12345000, 32'h80000000,
              32'h0000001F, 32'h0000001F, 32'hFFFFFFFC, 32'hFFFFFFF8};
    d_e64 = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'h0000000012345000,
              64'hFFFFFFFF80000000, 64'h000000000000003F, 64'h000000000000001F,
              64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8};

    // Reset values
    rst_n     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid32), 64'd0);
    chk("rst_in_ready", 64'(in_ready64), 64'd1);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_tag", 64'(tag32), 64'd0);
    chk("rst_ill", 64'(ill64), 64'd0);
    chk("rst_err", 64'(err32), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed formats, one beat at a time, out_ready high
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, d_ins[i], d_src[i], 5'(i + 1));
      cycle();
      chk("dir_valid", 64'(out_valid64), 64'd1);
      chk("dir_imm32", 64'(imm32), 64'(d_e32[i]));
      chk("dir_imm64", imm64, d_e64[i]);
      drive(1'b0, 32'h0, 3'd0, 5'd0);
      cycle();
    end

    // Illegal format produces zero immediate and the illegal flag
    drive(1'b1, 32'hFFFFFFFF, 3'd7, 5'd17);
    cycle();
    chk("dir_ill_imm", imm64, 64'd0);
    chk("dir_ill_flag", 64'(ill32), 64'd1);
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    cycle();

    // Randomised traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)),
            5'($urandom_range(0, 31)));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();

    // Backpressure: tags 1,2 accepted, 3 held, then drain without bubbles
    out_ready = 1'b0;
    drive(1'b1, $urandom, 3'd0, 5'd1);
    cycle();
    drive(1'b1, $urandom, 3'd1, 5'd2);
    cycle();
    chk("bp_in_ready_low", 64'(in_ready32), 64'd0);
    drive(1'b1, $urandom, 3'd2, 5'd3);
    cycle();
    chk("bp_stall_tag", 64'(tag64), 64'd1);
    out_ready = 1'b1;
    chk("bp_out1", 64'(tag32), 64'd1);
    cycle();
    chk("bp_out2", 64'(tag32), 64'd2);
    chk("bp_in_ready_back", 64'(in_ready64), 64'd1);
    cycle();
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    chk("bp_out3", 64'(tag32), 64'd3);
    chk("bp_out3_valid", 64'(out_valid32), 64'd1);
    cycle();
    chk("bp_empty", 64'(out_valid32), 64'd0);

    // 300 back-to-back illegal beats saturate the counter
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, $urandom, 3'd7, 5'(i));
      cycle();
    end
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    cycle();
    chk("err_sat32", 64'(err32), 64'd255);
    chk("err_sat64", 64'(err64), 64'd255);

    // Asynchronous reset with the skid entry full
    out_ready = 1'b0;
    drive(1'b1, $urandom, 3'd0, 5'd4);
    cycle();
    drive(1'b1, $urandom, 3'd7, 5'd5);
    cycle();
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    chk("pre_rst_in_ready", 64'(in_ready64), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid32", 64'(out_valid32), 64'd0);
    chk("arst_out_valid64", 64'(out_valid64), 64'd0);
    chk("arst_in_ready", 64'(in_ready32), 64'd1);
    chk("arst_err", 64'(err64), 64'd0);
    chk("arst_imm", imm64, 64'd0);
    q.delete();
    err_model = 0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 32'h12345037, 3'd4, 5'd9);
    cycle();
    chk("post_rst_imm32", 64'(imm32), 64'h12345000);
    chk("post_rst_tag", 64'(tag64), 64'd9);
    drive(1'b0, 32'h0, 3'd0, 5'd0);
    cycle();

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
